// File: rtl/sad_pkg.sv
// Shared types and width helpers for the parallel SAD block.
package sad_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CALC,
    S_CALC_END,
    S_DONE
  } state_e;

  function automatic int aw_f(input int n, input int depth);
    int steps;
    steps = depth / n;
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

  function automatic int sw_f(input int w, input int depth);
    return w + $clog2(depth);
  endfunction

endpackage

// File: rtl/sad_ctrl.sv
// Sequencer and step-address counter for sad_par.
// SAD_PAR_ABORT_EN adds an abort input that returns a run to IDLE.
module sad_ctrl
  import sad_pkg::*;
#(
  parameter int N     = 4,
  parameter int DEPTH = 16,
  localparam int AW   = aw_f(N, DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          init_i,
  input  logic          ack_i,
  input  logic          loaded_i,
`ifdef SAD_PAR_ABORT_EN
  input  logic          abort_i,
`endif
  output logic [AW-1:0] addr_o,
  output logic          rd_o,
  output logic          done_o,
  output logic          clr_o,
  output logic          cap_o,
  output logic          calc_o,
  output logic          latch_o
);

  localparam int STEPS = DEPTH / N;
  localparam logic [AW-1:0] LAST = AW'(STEPS - 1);

  state_e        state_q;
  logic [AW-1:0] addr_q;
  logic          rd_q;
  logic          done_q;
  logic          abort;

`ifdef SAD_PAR_ABORT_EN
  assign abort = abort_i &
    (state_q inside {S_LOAD, S_CALC, S_CALC_END});
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      done_q  <= 1'b0;
    end else if (abort) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          addr_q <= '0;
          if (init_i) begin
            state_q <= S_LOAD;
            rd_q    <= 1'b1;
          end
        end
        S_LOAD: begin
          if (loaded_i) begin
            state_q <= S_CALC;
            rd_q    <= 1'b0;
          end
        end
        S_CALC: begin
          if (addr_q == LAST) begin
            state_q <= S_CALC_END;
          end else begin
            addr_q  <= addr_q + 1'b1;
            state_q <= S_LOAD;
            rd_q    <= 1'b1;
          end
        end
        S_CALC_END: begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
        end
        S_DONE: begin
          if (ack_i) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          addr_q  <= '0;
          rd_q    <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign addr_o  = addr_q;
  assign rd_o    = rd_q;
  assign done_o  = done_q;
  assign clr_o   = (state_q == S_IDLE);
  assign cap_o   = (state_q == S_LOAD) & loaded_i & ~abort;
  assign calc_o  = (state_q == S_CALC) & ~abort;
  assign latch_o = (state_q == S_CALC_END) & ~abort;

endmodule

// File: rtl/sad_par.sv
// Block sum of absolute differences over N parallel pixel lanes.
// SAD_PAR_ABORT_EN adds an abort input that cancels a run in progress.
module sad_par
  import sad_pkg::*;
#(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int DEPTH = 16,
  localparam int AW   = aw_f(N, DEPTH),
  localparam int SW   = sw_f(W, DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           init_i,
  input  logic           ack_i,
  input  logic           loaded_i,
`ifdef SAD_PAR_ABORT_EN
  input  logic           abort_i,
`endif
  input  logic [N*W-1:0] pa_i,
  input  logic [N*W-1:0] pb_i,
  output logic [AW-1:0]  addr_o,
  output logic           rd_o,
  output logic [SW-1:0]  sad_o,
  output logic           done_o
);

  logic           clr;
  logic           cap;
  logic           calc;
  logic           latch;
  logic [N*W-1:0] pa_q;
  logic [N*W-1:0] pb_q;
  logic [SW-1:0]  acc_q;
  logic [SW-1:0]  acc_d;
  logic [SW-1:0]  sad_q;
  logic [SW-1:0]  lane_sum;

  sad_ctrl #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .init_i   (init_i),
    .ack_i    (ack_i),
    .loaded_i (loaded_i),
`ifdef SAD_PAR_ABORT_EN
    .abort_i  (abort_i),
`endif
    .addr_o   (addr_o),
    .rd_o     (rd_o),
    .done_o   (done_o),
    .clr_o    (clr),
    .cap_o    (cap),
    .calc_o   (calc),
    .latch_o  (latch)
  );

  // One extra bit keeps the sign of a - b before folding.
  function automatic logic [W-1:0] absd(
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    logic [W:0] d;
    logic [W:0] n;
    d = {1'b0, a} - {1'b0, b};
    n = -d;
    return d[W] ? n[W-1:0] : d[W-1:0];
  endfunction

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < N; i++) begin
      lane_sum = lane_sum +
        SW'(absd(pa_q[i*W +: W], pb_q[i*W +: W]));
    end
  end

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (calc) begin
      acc_d = acc_q + lane_sum;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pa_q  <= '0;
      pb_q  <= '0;
      acc_q <= '0;
      sad_q <= '0;
    end else begin
      acc_q <= acc_d;
      if (cap) begin
        pa_q <= pa_i;
        pb_q <= pb_i;
      end
      if (latch) begin
        sad_q <= acc_q;
      end
    end
  end

  assign sad_o = sad_q;

endmodule

// File: tb/tb_sad_par.sv
// Directed self-checking bench for sad_par (default and STEPS=1 builds).
module tb_sad_par;

  logic        clk = 1'b0;
  logic        rst;
  logic        init, init1, ack, loaded;
  logic        use_mem;
  logic [31:0] pa_drv, pb_drv, mem_pa;
  logic [31:0] pa, pb;
  logic [1:0]  addr;
  logic        rd, done;
  logic [11:0] sad;
  logic [0:0]  addr1;
  logic        rd1, done1;
  logic [9:0]  sad1;
`ifdef SAD_PAR_ABORT_EN
  logic        abort;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Memory model: lane i of step a holds 8*a + i; B is flat 20.
  always_comb begin
    mem_pa = '0;
    for (int i = 0; i < 4; i++)
      mem_pa[i*8 +: 8] = 8'(8 * int'(addr) + i);
  end
  assign pa = use_mem ? mem_pa : pa_drv;
  assign pb = use_mem ? {4{8'd20}} : pb_drv;

  sad_par #(.N(4), .W(8), .DEPTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .init_i   (init),
    .ack_i    (ack),
    .loaded_i (loaded),
`ifdef SAD_PAR_ABORT_EN
    .abort_i  (abort),
`endif
    .pa_i     (pa),
    .pb_i     (pb),
    .addr_o   (addr),
    .rd_o     (rd),
    .sad_o    (sad),
    .done_o   (done)
  );

  sad_par #(.N(4), .W(8), .DEPTH(4)) dut1 (
    .clk      (clk),
    .rst      (rst),
    .init_i   (init1),
    .ack_i    (ack),
    .loaded_i (loaded),
`ifdef SAD_PAR_ABORT_EN
    .abort_i  (1'b0),
`endif
    .pa_i     (pa),
    .pb_i     (pb),
    .addr_o   (addr1),
    .rd_o     (rd1),
    .sad_o    (sad1),
    .done_o   (done1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    init = 1'b1;
    tick();
    init = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (done) begin
        cyc = k;
        return;
      end
    end
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++;
    if ({done, rd, addr, sad} !== '0) begin
      errors++;
      $display("FAIL reset: done=%0b rd=%0b addr=%0d sad=%0d required 0",
               done, rd, addr, sad);
    end
    checks++;
    if ({done1, rd1, addr1, sad1} !== '0) begin
      errors++;
      $display("FAIL reset_s1: done=%0b rd=%0b sad=%0d required 0",
               done1, rd1, sad1);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int cyc;
    pa_drv = {4{8'd10}};
    pb_drv = {4{8'd3}};
    start();
    checks++;
    if (rd !== 1'b1 || addr !== 2'd0) begin
      errors++;
      $display("FAIL first_load: rd=%0b addr=%0d required rd=1 addr=0",
               rd, addr);
    end
    wait_done(cyc);
    checks++;
    if (cyc !== 9) begin
      errors++;
      $display("FAIL latency: got %0d required 9", cyc);
    end
    checks++;
    if (sad !== 12'd112) begin
      errors++;
      $display("FAIL basic_sad: got %0d required 112", sad);
    end
    do_ack();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL ack_clear: done=%0b required 0", done);
    end
  endtask

  task automatic test_max();
    int n;
    logic [1:0] seq [4];
    pa_drv = '0;
    pb_drv = {4{8'd255}};
    n = 0;
    start();
    for (int k = 0; k < 100 && !done; k++) begin
      if (rd) begin
        if (n < 4) seq[n] = addr;
        n++;
      end
      tick();
    end
    checks++;
    if (sad !== 12'd4080) begin
      errors++;
      $display("FAIL max_sad: got %0d required 4080", sad);
    end
    checks++;
    if (n !== 4 || seq[0] !== 2'd0 || seq[1] !== 2'd1 ||
        seq[2] !== 2'd2 || seq[3] !== 2'd3) begin
      errors++;
      $display("FAIL addr_seq: got n=%0d %0d,%0d,%0d,%0d required 0,1,2,3",
               n, seq[0], seq[1], seq[2], seq[3]);
    end
    do_ack();
  endtask

  task automatic test_mem();
    int cyc;
    use_mem = 1'b1;
    start();
    wait_done(cyc);
    checks++;
    if (sad !== 12'd148 || cyc !== 9) begin
      errors++;
      $display("FAIL mem_sad: got %0d cyc %0d required 148 cyc 9",
               sad, cyc);
    end
    do_ack();
    use_mem = 1'b0;
  endtask

  task automatic test_stall();
    int stalls, bad, cyc;
    pa_drv = {4{8'd10}};
    pb_drv = {4{8'd3}};
    stalls = 0;
    bad = 0;
    cyc = -1;
    start();
    for (int k = 1; k <= 100; k++) begin
      if (rd && addr == 2'd2 && stalls < 5) begin
        loaded = 1'b0;
        stalls++;
      end else begin
        if (stalls > 0 && stalls <= 5 && !(rd && addr == 2'd2) &&
            addr == 2'd2 && loaded == 1'b0)
          bad++;
        loaded = 1'b1;
      end
      tick();
      if (!loaded && (rd !== 1'b1 || addr !== 2'd2)) bad++;
      if (done) begin
        cyc = k;
        break;
      end
    end
    loaded = 1'b1;
    checks++;
    if (bad !== 0 || stalls !== 5) begin
      errors++;
      $display("FAIL stall_hold: bad=%0d stalls=%0d required 0 and 5",
               bad, stalls);
    end
    checks++;
    if (cyc !== 14 || sad !== 12'd112) begin
      errors++;
      $display("FAIL stall_done: cyc=%0d sad=%0d required 14 and 112",
               cyc, sad);
    end
    do_ack();
  endtask

  task automatic test_rst_mid();
    int cyc;
    pa_drv = {4{8'd10}};
    pb_drv = {4{8'd3}};
    start();
    for (int k = 0; k < 20 && !(!rd && addr == 2'd1); k++) tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({done, rd, addr, sad} !== '0) begin
      errors++;
      $display("FAIL rst_mid: done=%0b rd=%0b addr=%0d sad=%0d required 0",
               done, rd, addr, sad);
    end
    #1;
    rst = 1'b0;
    tick();
    use_mem = 1'b1;
    start();
    wait_done(cyc);
    checks++;
    if (sad !== 12'd148) begin
      errors++;
      $display("FAIL rst_rerun: got %0d required 148", sad);
    end
    use_mem = 1'b0;
  endtask

  task automatic test_hold();
    int bad;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (done !== 1'b1 || sad !== 12'd148) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL done_hold: %0d bad cycles required 0", bad);
    end
    init = 1'b1;
    ack = 1'b1;
    tick();
    init = 1'b0;
    ack = 1'b0;
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      if (done !== 1'b0 || rd !== 1'b0 || addr !== 2'd0) bad++;
      tick();
    end
    checks++;
    if (bad !== 0 || sad !== 12'd148) begin
      errors++;
      $display("FAIL no_restart: bad=%0d sad=%0d required 0 and 148",
               bad, sad);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    pa_drv = {4{8'd200}};
    pb_drv = {4{8'd201}};
    start();
    wait_done(cyc);
    checks++;
    if (sad !== 12'd16 || cyc !== 9) begin
      errors++;
      $display("FAIL b2b_sad: got %0d cyc %0d required 16 cyc 9", sad, cyc);
    end
    do_ack();
    init = 1'b1;
    tick();
    init = 1'b0;
    checks++;
    if (rd !== 1'b1 || addr !== 2'd0) begin
      errors++;
      $display("FAIL b2b_restart: rd=%0b addr=%0d required 1 and 0",
               rd, addr);
    end
    wait_done(cyc);
    do_ack();
  endtask

  task automatic test_steps1();
    int cyc;
    pa_drv = {4{8'd10}};
    pb_drv = {4{8'd3}};
    cyc = -1;
    init1 = 1'b1;
    tick();
    init1 = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (done1) begin
        cyc = k;
        break;
      end
    end
    checks++;
    if (cyc !== 3 || sad1 !== 10'd28 || addr1 !== 1'b0) begin
      errors++;
      $display("FAIL steps1: cyc=%0d sad=%0d addr=%0d required 3, 28, 0",
               cyc, sad1, addr1);
    end
    do_ack();
  endtask

`ifdef SAD_PAR_ABORT_EN
  task automatic test_abort();
    int cyc;
    pa_drv = {4{8'd10}};
    pb_drv = {4{8'd3}};
    start();
    wait_done(cyc);
    do_ack();
    start();
    for (int k = 0; k < 20 && !(rd && addr == 2'd2); k++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (rd !== 1'b0 || done !== 1'b0 || addr !== 2'd0 ||
        sad !== 12'd112) begin
      errors++;
      $display("FAIL abort: rd=%0b done=%0b addr=%0d sad=%0d required 0,0,0,112",
               rd, done, addr, sad);
    end
    tick();
    checks++;
    if (rd !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: rd=%0b done=%0b required 0", rd, done);
    end
  endtask
`endif

  initial begin
    rst = 1'b0;
    init = 1'b0;
    init1 = 1'b0;
    ack = 1'b0;
    loaded = 1'b1;
    use_mem = 1'b0;
    pa_drv = '0;
    pb_drv = '0;
`ifdef SAD_PAR_ABORT_EN
    abort = 1'b0;
`endif
    #1;
    test_reset();
    test_basic();
    test_max();
    test_mem();
    test_stall();
    test_rst_mid();
    test_hold();
    test_back_to_back();
    test_steps1();
`ifdef SAD_PAR_ABORT_EN
    test_abort();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
